// File: rtl/sha256_digest_streamer_pkg.sv
// Shared sha256 definitions: word/digest geometry and the streamer FSM state type.
package sha256_digest_streamer_pkg;

  localparam int SHA_WORD_W       = 32;
  localparam int SHA_DIGEST_W     = 256;
  localparam int SHA_DIGEST_WORDS = 8;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } sha_state_e;

endpackage

// File: rtl/sha256_digest_fifo.sv
// Small digest buffer (1 or 2 slots). A push is still accepted when the
// buffer is full, provided a pop frees the head slot in the same cycle.
module sha256_digest_fifo
  import sha256_digest_streamer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [SHA_DIGEST_W-1:0] push_data_i,
  output logic [SHA_DIGEST_W-1:0] head_o,
  output logic                    push_ok_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [1:0]              count_o
);

  logic [SHA_DIGEST_W-1:0] mem_q [DEPTH];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    pop_do;

  function automatic logic ptr_inc(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  assign full_o    = (count_q == 2'(DEPTH));
  assign empty_o   = (count_q == 2'd0);
  assign pop_do    = pop_i && !empty_o;
  assign push_ok_o = push_i && (!full_o || pop_do);
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_o) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_do)    rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + {1'b0, push_ok_o} - {1'b0, pop_do};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sha256_digest_streamer.sv
// Captures 256-bit digests on the rising edge of output_valid and streams each
// one out as eight 32-bit words over a valid/ready handshake.
module sha256_digest_streamer
  import sha256_digest_streamer_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int DIGEST_W  = 256,
  parameter int DEPTH     = 2,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGEST_W-1:0] hash_data,
  input  logic                output_valid,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                overflow,
  output logic [1:0]          pending
);

  sha_state_e              state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic                    ov_prev_q;
  logic                    overflow_q, overflow_d;
  logic                    capture;
  logic                    handshake;
  logic                    pop;
  logic                    push_ok;
  logic                    full;
  logic                    empty;
  logic [1:0]              count;
  logic [SHA_DIGEST_W-1:0] head;
  logic [2:0]              word_sel;

  assign capture   = output_valid && !ov_prev_q;
  assign handshake = (state_q == ST_STREAM) && out_ready;
  assign pop       = handshake && (idx_q == 3'd7);

  sha256_digest_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (capture),
    .pop_i      (pop),
    .push_data_i(hash_data),
    .head_o     (head),
    .push_ok_o  (push_ok),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    overflow_d = capture && full && !push_ok;
    case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (!empty || push_ok) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (handshake) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            // Last word of the only buffered digest, nothing arriving: go idle.
            if (count == 2'd1 && !push_ok) state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      ov_prev_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ov_prev_q  <= output_valid;
      overflow_q <= overflow_d;
    end
  end

  // With MSW_FIRST, word 0 is the top 32 bits (H0) of the digest.
  assign word_sel  = MSW_FIRST ? ~idx_q : idx_q;
  assign out_valid = (state_q == ST_STREAM);
  assign out_last  = (state_q == ST_STREAM) && (idx_q == 3'd7);
  assign out_data  = (state_q == ST_STREAM) ? head[{word_sel, 5'b0} +: SHA_WORD_W] : '0;
  assign overflow  = overflow_q;
  assign pending   = count;

endmodule
